// File: rtl/sample_fifo_writer.sv
// Producer front end for the sample FIFO: captures one frame of optionally decimated ADC samples.
// Define SAMPLE_WRITER_DROP_CNT_EN to count samples dropped while the FIFO is almost full.
module sample_fifo_writer #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned DECIM     = 1,
  parameter int unsigned FRAME_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              almost_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              done,
  output logic [15:0]       drop_cnt
);

  localparam logic [7:0]  DecimLast = 8'(DECIM - 1);
  localparam logic [15:0] FrameLen  = 16'(FRAME_LEN);

  typedef enum logic [1:0] {StIdle, StCapture, StFinish} state_e;

  state_e            state_q, state_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              frame_full;
  logic              sel;

  // Once the last write is issued the frame is closed; later samples are ignored.
  assign frame_full = (wcnt_q == FrameLen);
  assign sel        = (state_q == StCapture) && !frame_full && adc_valid && (dcnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    wr_en_d = 1'b0;
    din_d   = din_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCapture;
          dcnt_d  = 8'd0;
          wcnt_d  = 16'd0;
        end
      end
      StCapture: begin
        if (frame_full) begin
          state_d = StFinish;
        end else if (adc_valid) begin
          dcnt_d = (dcnt_q == DecimLast) ? 8'd0 : dcnt_q + 8'd1;
          if (sel && !almost_full) begin
            wr_en_d = 1'b1;
            din_d   = adc_data;
            wcnt_d  = wcnt_q + 16'd1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dcnt_q  <= 8'd0;
      wcnt_q  <= 16'd0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      wcnt_q  <= wcnt_d;
      wr_en_q <= wr_en_d;
      din_q   <= din_d;
    end
  end

`ifdef SAMPLE_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  assign drop = sel && almost_full;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == StIdle) && start) begin
      drop_cnt_d = 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

  assign wr_en = wr_en_q;
  assign din   = din_q;
  assign busy  = (state_q == StCapture);
  assign done  = (state_q == StFinish);

endmodule

// File: tb/tb_sample_fifo_writer.sv
// Bench for sample_fifo_writer: three instances with different DECIM/FRAME_LEN share one stimulus,
// checked each cycle against a frame-level model plus hand-computed write sequences.
module tb_sample_fifo_writer;
  localparam int N = 3;
  localparam int DECIM_P [N] = '{1, 3, 2};
  localparam int FLEN_P  [N] = '{8, 4, 8};
`ifdef SAMPLE_WRITER_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, adc_valid, almost_full;
  logic [11:0] adc_data;
  logic        wr_en [N];
  logic [11:0] din [N];
  logic        busy [N];
  logic        done [N];
  logic [15:0] drop_cnt [N];

  sample_fifo_writer #(.DATA_W(12), .DECIM(DECIM_P[0]), .FRAME_LEN(FLEN_P[0])) dut_a (
    .clk(clk), .rst(rst), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
    .almost_full(almost_full), .wr_en(wr_en[0]), .din(din[0]), .busy(busy[0]),
    .done(done[0]), .drop_cnt(drop_cnt[0]));
  sample_fifo_writer #(.DATA_W(12), .DECIM(DECIM_P[1]), .FRAME_LEN(FLEN_P[1])) dut_b (
    .clk(clk), .rst(rst), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
    .almost_full(almost_full), .wr_en(wr_en[1]), .din(din[1]), .busy(busy[1]),
    .done(done[1]), .drop_cnt(drop_cnt[1]));
  sample_fifo_writer #(.DATA_W(12), .DECIM(DECIM_P[2]), .FRAME_LEN(FLEN_P[2])) dut_c (
    .clk(clk), .rst(rst), .start(start), .adc_valid(adc_valid), .adc_data(adc_data),
    .almost_full(almost_full), .wr_en(wr_en[2]), .din(din[2]), .busy(busy[2]),
    .done(done[2]), .drop_cnt(drop_cnt[2]));

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 capturing, 2 done cycle; vcnt counts valid samples since start.
  int          m_phase [N];
  int          m_vcnt [N];
  int          m_writes [N];
  int          m_drops [N];
  logic        m_wr [N];
  logic [11:0] m_din [N];

  int mq [N][32];
  int mn [N];
  int dq [N][32];
  int dn [N];
  int dd [N];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      m_wr[k] = 1'b0;
      if (rst) begin
        m_phase[k]  = 0;
        m_vcnt[k]   = 0;
        m_writes[k] = 0;
        m_drops[k]  = 0;
        m_din[k]    = '0;
      end else begin
        case (m_phase[k])
          0: if (start) begin
            m_phase[k]  = 1;
            m_vcnt[k]   = 0;
            m_writes[k] = 0;
            m_drops[k]  = 0;
          end
          1: begin
            if (m_writes[k] == FLEN_P[k]) begin
              m_phase[k] = 2;
            end else if (adc_valid) begin
              if (m_vcnt[k] % DECIM_P[k] == 0) begin
                if (almost_full) begin
                  if (EXP_DROP != 0 && m_drops[k] < 65535) m_drops[k]++;
                end else begin
                  m_wr[k]  = 1'b1;
                  m_din[k] = adc_data;
                  m_writes[k]++;
                  if (mn[k] < 32) mq[k][mn[k]] = $signed(adc_data);
                  mn[k]++;
                end
              end
              m_vcnt[k]++;
            end
          end
          default: m_phase[k] = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check("wr_en", k, 32'(wr_en[k]), 32'(m_wr[k]));
        check("din", k, 32'(din[k]), 32'(m_din[k]));
        check("busy", k, 32'(busy[k]), 32'(m_phase[k] == 1));
        check("done", k, 32'(done[k]), 32'(m_phase[k] == 2));
        check("drop_cnt", k, 32'(drop_cnt[k]), 32'(m_drops[k]));
        if (wr_en[k] === 1'b1) begin
          if (dn[k] < 32) dq[k][dn[k]] = $signed(din[k]);
          dn[k]++;
        end
        if (done[k] === 1'b1) dd[k]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    for (int k = 0; k < N; k++) begin
      mn[k] = 0;
      dn[k] = 0;
      dd[k] = 0;
    end
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive count ramp samples from first; almost_full over [af_lo, af_hi]; optional extra start.
  task automatic feed(input int first, input int count, input bit gapped, input int af_lo,
                      input int af_hi, input int start_at);
    for (int i = 0; i < count; i++) begin
      adc_valid   = 1'b1;
      adc_data    = 12'(first + i);
      almost_full = (first + i >= af_lo) && (first + i <= af_hi);
      start       = (i == start_at);
      tick();
      if (gapped) begin
        adc_valid   = 1'b0;
        almost_full = 1'b0;
        start       = 1'b0;
        tick();
      end
    end
    adc_valid   = 1'b0;
    almost_full = 1'b0;
    start       = 1'b0;
  endtask

  // Compare both the DUT log and the model log of dut k against a literal sequence.
  task automatic check_writes(input string name, input int k, input int n, input int mode);
    int exp;
    check({name, "_count"}, k, 32'(dn[k]), 32'(n));
    check({name, "_model_count"}, k, 32'(mn[k]), 32'(n));
    for (int i = 0; i < n && i < 32; i++) begin
      case (mode)
        0:       exp = i;
        1:       exp = i - 4;
        2:       exp = 3 * i;
        3:       exp = 2 * i;
        default: exp = (i < 3) ? i : i + 3;
      endcase
      check({name, "_din"}, k, 32'(dq[k][i]), 32'(exp));
      check({name, "_model_din"}, k, 32'(mq[k][i]), 32'(exp));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    adc_valid = 1'b0;
    adc_data = '0;
    almost_full = 1'b0;
    clear_logs();
    tick();
    chk_en = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      check("rst_wr_en", k, 32'(wr_en[k]), 32'd0);
      check("rst_din", k, 32'(din[k]), 32'd0);
      check("rst_busy", k, 32'(busy[k]), 32'd0);
      check("rst_done", k, 32'(done[k]), 32'd0);
      check("rst_drop", k, 32'(drop_cnt[k]), 32'd0);
    end
    rst = 1'b0;
    idle(2);

    // Reset mid-frame at the 4th write, then a clean frame.
    clear_logs();
    begin_frame();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(i);
      tick();
    end
    check("mid_4th_wr", 0, 32'(wr_en[0]), 32'd1);
    check("mid_4th_din", 0, 32'(din[0]), 32'd3);
    rst = 1'b1;
    adc_data = 12'd4;
    tick();
    check("mid_rst_wr_en", 0, 32'(wr_en[0]), 32'd0);
    check("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    check("mid_rst_drop", 0, 32'(drop_cnt[0]), 32'd0);
    rst = 1'b0;
    adc_valid = 1'b0;
    tick();
    clear_logs();
    begin_frame();
    feed(0, 16, 1'b0, 1000, 999, -1);
    idle(25);
    check_writes("restart", 0, 8, 0);
    check("restart_done", 0, 32'(dd[0]), 32'd1);

    // Basic frame, -4..3, with first-write latency pinned.
    clear_logs();
    begin_frame();
    check("basic_busy_t1", 0, 32'(busy[0]), 32'd1);
    check("basic_wr_t1", 0, 32'(wr_en[0]), 32'd0);
    adc_valid = 1'b1;
    adc_data  = 12'hFFC;
    tick();
    check("basic_lat_wr", 0, 32'(wr_en[0]), 32'd1);
    check("basic_lat_din", 0, 32'(din[0]), 32'h0000_0FFC);
    feed(-3, 15, 1'b0, 1000, 999, -1);
    idle(25);
    check_writes("basic", 0, 8, 1);
    check("basic_done", 0, 32'(dd[0]), 32'd1);
    check("basic_busy_end", 0, 32'(busy[0]), 32'd0);

    // Decimation by 3 on a continuous ramp.
    clear_logs();
    begin_frame();
    feed(0, 21, 1'b0, 1000, 999, -1);
    idle(25);
    check_writes("decim3", 1, 4, 2);
    check("decim3_done", 1, 32'(dd[1]), 32'd1);
    check_writes("decim2_cont", 2, 8, 3);

    // Gapped valid with decimation by 2.
    clear_logs();
    begin_frame();
    feed(0, 16, 1'b1, 1000, 999, -1);
    idle(25);
    check_writes("gapped", 2, 8, 3);
    check("gapped_done", 2, 32'(dd[2]), 32'd1);

    // Backpressure on samples 3..5.
    clear_logs();
    begin_frame();
    feed(0, 20, 1'b0, 3, 5, -1);
    idle(25);
    check_writes("bp", 0, 8, 4);
    check("bp_drop", 0, 32'(drop_cnt[0]), 32'(EXP_DROP));
    check("bp_model_drop", 0, 32'(m_drops[0]), 32'(EXP_DROP));

    // Second start mid-frame is ignored.
    clear_logs();
    begin_frame();
    feed(0, 16, 1'b0, 1000, 999, 3);
    idle(25);
    check_writes("restart_busy", 0, 8, 0);
    check("restart_busy_done", 0, 32'(dd[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
